// File: rtl/gpu_ctrl_pkg.sv
// Shared constants for the GPU CPU-bus front end: status bit layout, IRQ
// source indices, mask reset value and the read-select decode.
package gpu_ctrl_pkg;

  localparam int ST_WRITABLE = 0;
  localparam int ST_VBLANK   = 1;
  localparam int ST_LINE     = 2;
  localparam int ST_EMPTY    = 5;
  localparam int ST_FULL     = 6;
  localparam int ST_OVERFLOW = 7;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_LINE   = 1;
  localparam int IRQ_W      = 2;

  localparam logic [7:0] MASK_RST = 8'h01;

  typedef enum logic [2:0] {
    RD_NONE,
    RD_STATUS,
    RD_MASK,
    RD_LINE,
    RD_FRAME
  } rd_sel_e;

  // Selects are one-hot from the bus decode; the priority only breaks ties.
  function automatic rd_sel_e rd_decode(input logic s_status, input logic s_mask,
                                        input logic s_line, input logic s_frame);
    if (s_status)     return RD_STATUS;
    else if (s_mask)  return RD_MASK;
    else if (s_line)  return RD_LINE;
    else if (s_frame) return RD_FRAME;
    else              return RD_NONE;
  endfunction

endpackage

// File: rtl/gpu_write_fifo.sv
// Synchronous write-posting FIFO. Pointers carry a wrap bit so full and
// empty are distinguished without a separate counter.
module gpu_write_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gpu_ctrl.sv
// CPU-bus front end: masked vblank/line interrupt controller plus a VRAM
// write-posting FIFO drained while video timing reports writable.
// Define GPU_CTRL_LINE_IRQ_EN to build the line-compare interrupt source.
module gpu_ctrl
  import gpu_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int LINE_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data_in,
  input  logic [ADDR_W-1:0] address,
  input  logic              write_enable,
  input  logic              SELECT_vram,
  input  logic              SELECT_status,
  input  logic              SELECT_irq_clr,
  input  logic              SELECT_irq_mask,
  input  logic              SELECT_line_cmp,
  input  logic              SELECT_frame,
  output logic [7:0]        data_out,
  input  logic              writable,
  input  logic [LINE_W-1:0] vcounter,
  output logic [7:0]        vram_wdata,
  output logic [ADDR_W-1:0] vram_waddr,
  output logic              vram_we,
  output logic              irq
);

  localparam int FW = ADDR_W + 8;

  logic              full, empty, push, pop;
  logic [FW-1:0]     head;
  logic              overflow_q, wr_q, wr_rise, status_rd;
  logic [7:0]        frame_q, status, line_cmp_rd;
  logic [IRQ_W-1:0]  pend_q, mask_q, pend_set, pend_clr;
  logic              line_hit;

  assign push = write_enable && SELECT_vram;
  assign pop  = writable && !empty;

  gpu_write_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push && !full),
    .pop   (pop),
    .wdata ({address, data_in}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign {vram_waddr, vram_wdata} = head;
  assign vram_we = pop;

  assign wr_rise   = writable && !wr_q;
  assign status_rd = SELECT_status && !write_enable;

`ifdef GPU_CTRL_LINE_IRQ_EN
  localparam logic [IRQ_W-1:0] MASK_VALID = 2'b11;
  logic [7:0]        line_cmp_q;
  logic [LINE_W-1:0] vcnt_q;

  // Only a change onto the compare line fires; holding the line does not.
  assign line_hit    = (vcounter != vcnt_q) && (vcounter == LINE_W'(line_cmp_q));
  assign line_cmp_rd = line_cmp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_cmp_q <= '0;
      vcnt_q     <= '0;
    end else begin
      vcnt_q <= vcounter;
      if (write_enable && SELECT_line_cmp) line_cmp_q <= data_in;
    end
  end
`else
  localparam logic [IRQ_W-1:0] MASK_VALID = 2'b01;
  logic unused_ok;

  assign line_hit    = 1'b0;
  assign line_cmp_rd = 8'h00;
  assign unused_ok   = ^vcounter;
`endif

  always_comb begin
    pend_set = '0;
    pend_set[IRQ_VBLANK] = wr_rise;
    pend_set[IRQ_LINE]   = line_hit;
    pend_clr = (write_enable && SELECT_irq_clr) ? data_in[IRQ_W-1:0] : '0;
  end

  // Set is OR'd after the clear so a coincident event survives its clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q     <= '0;
      mask_q     <= MASK_RST[IRQ_W-1:0];
      overflow_q <= 1'b0;
      wr_q       <= 1'b0;
      frame_q    <= '0;
    end else begin
      pend_q <= pend_set | (pend_q & ~pend_clr);
      wr_q   <= writable;
      if (wr_rise) frame_q <= frame_q + 8'd1;
      if (write_enable && SELECT_irq_mask) mask_q <= data_in[IRQ_W-1:0] & MASK_VALID;
      if (push && full)   overflow_q <= 1'b1;
      else if (status_rd) overflow_q <= 1'b0;
    end
  end

  assign irq = |(pend_q & mask_q);

  always_comb begin
    status = '0;
    status[ST_OVERFLOW] = overflow_q;
    status[ST_FULL]     = full;
    status[ST_EMPTY]    = empty;
    status[ST_LINE]     = pend_q[IRQ_LINE];
    status[ST_VBLANK]   = pend_q[IRQ_VBLANK];
    status[ST_WRITABLE] = writable;
  end

  always_comb begin
    data_out = 8'h00;
    case (rd_decode(SELECT_status, SELECT_irq_mask, SELECT_line_cmp, SELECT_frame))
      RD_STATUS: data_out = status;
      RD_MASK:   data_out = {{(8-IRQ_W){1'b0}}, mask_q};
      RD_LINE:   data_out = line_cmp_rd;
      RD_FRAME:  data_out = frame_q;
      default:   data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_gpu_ctrl.sv
// Directed bench for gpu_ctrl: reset, drain, overflow, IRQ, line compare,
// back-to-back push/pop and reset during a drain.
module tb_gpu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic [11:0] address;
  logic        write_enable, SELECT_vram, SELECT_status, SELECT_irq_clr;
  logic        SELECT_irq_mask, SELECT_line_cmp, SELECT_frame;
  logic [7:0]  data_out;
  logic        writable;
  logic [9:0]  vcounter;
  logic [7:0]  vram_wdata;
  logic [11:0] vram_waddr;
  logic        vram_we, irq;

  int errs = 0;
  int checks = 0;

  gpu_ctrl #(.ADDR_W(12), .FIFO_DEPTH(8), .LINE_W(10)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .address(address),
    .write_enable(write_enable), .SELECT_vram(SELECT_vram),
    .SELECT_status(SELECT_status), .SELECT_irq_clr(SELECT_irq_clr),
    .SELECT_irq_mask(SELECT_irq_mask), .SELECT_line_cmp(SELECT_line_cmp),
    .SELECT_frame(SELECT_frame), .data_out(data_out), .writable(writable),
    .vcounter(vcounter), .vram_wdata(vram_wdata), .vram_waddr(vram_waddr),
    .vram_we(vram_we), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic idle();
    write_enable = 0; SELECT_vram = 0; SELECT_status = 0; SELECT_irq_clr = 0;
    SELECT_irq_mask = 0; SELECT_line_cmp = 0; SELECT_frame = 0;
    data_in = 0; address = 0;
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    idle(); writable = 0; vcounter = 0; rst = 0;
    tick(); tick(); rst = 1; tick();
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [7:0] d);
    address = a; data_in = d; SELECT_vram = 1; write_enable = 1;
    tick(); idle();
  endtask

  // sel: 0 irq_clr, 1 mask, 2 line_cmp
  task automatic reg_wr(input int sel, input logic [7:0] d);
    data_in = d; write_enable = 1;
    case (sel)
      0: SELECT_irq_clr = 1;
      1: SELECT_irq_mask = 1;
      default: SELECT_line_cmp = 1;
    endcase
    tick(); idle();
  endtask

  // sel: 0 status, 1 mask, 2 line_cmp, 3 frame
  task automatic reg_rd(input int sel, output logic [7:0] v);
    case (sel)
      0: SELECT_status = 1;
      1: SELECT_irq_mask = 1;
      2: SELECT_line_cmp = 1;
      default: SELECT_frame = 1;
    endcase
    #1 v = data_out;
    tick(); idle();
  endtask

  task automatic test_reset();
    logic [7:0] v;
    idle(); writable = 0; vcounter = 0; rst = 0; #3;
    checks++; if (vram_we !== 1'b0) begin errs++; $display("FAIL rst_we: got %b want 0", vram_we); end
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL rst_irq: got %b want 0", irq); end
    checks++; if (data_out !== 8'h00) begin errs++; $display("FAIL rst_dout: got %h want 00", data_out); end
    tick(); rst = 1; tick();
    reg_rd(0, v);
    checks++; if (v !== 8'h20) begin errs++; $display("FAIL rst_status: got %h want 20", v); end
    reg_rd(1, v);
    checks++; if (v !== 8'h01) begin errs++; $display("FAIL rst_mask: got %h want 01", v); end
    reg_rd(3, v);
    checks++; if (v !== 8'h00) begin errs++; $display("FAIL rst_frame: got %h want 00", v); end
    writable = 1; SELECT_status = 1; #1;
    checks++; if (data_out !== 8'h21) begin errs++; $display("FAIL rst_status_wr: got %h want 21", data_out); end
    tick(); idle(); writable = 0;
  endtask

  task automatic test_drain();
    logic [11:0] ea [3] = '{12'h010, 12'h011, 12'h012};
    logic [7:0]  ed [3] = '{8'hAA, 8'hBB, 8'hCC};
    logic [7:0]  v;
    do_reset();
    for (int i = 0; i < 3; i++) push_wr(ea[i], ed[i]);
    checks++; if (vram_we !== 1'b0) begin errs++; $display("FAIL drain_hold: got %b want 0", vram_we); end
    writable = 1; #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({vram_we, vram_waddr, vram_wdata} !== {1'b1, ea[i], ed[i]}) begin
        errs++; $display("FAIL drain_%0d: got we=%b a=%h d=%h want 1 %h %h", i, vram_we, vram_waddr, vram_wdata, ea[i], ed[i]);
      end
      tick(); #1;
    end
    checks++; if (vram_we !== 1'b0) begin errs++; $display("FAIL drain_stop: got %b want 0", vram_we); end
    reg_rd(0, v);
    checks++; if (v !== 8'h23) begin errs++; $display("FAIL drain_status: got %h want 23", v); end
    writable = 0; tick();
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 9; i++) push_wr(12'h100 + 12'(i), 8'h40 + 8'(i));
    reg_rd(0, v);
    checks++; if (v !== 8'hC0) begin errs++; $display("FAIL ovf_status: got %h want c0", v); end
    reg_rd(0, v);
    checks++; if (v !== 8'h40) begin errs++; $display("FAIL ovf_clear: got %h want 40", v); end
    // Push while full with a same-cycle pop: push is still dropped.
    writable = 1; address = 12'h0FF; data_in = 8'h99; SELECT_vram = 1; write_enable = 1; #1;
    checks++;
    if ({vram_we, vram_waddr, vram_wdata} !== {1'b1, 12'h100, 8'h40}) begin
      errs++; $display("FAIL ovf_head0: got we=%b a=%h d=%h want 1 100 40", vram_we, vram_waddr, vram_wdata);
    end
    tick(); idle();
    SELECT_status = 1; #1;
    checks++; if (data_out !== 8'h83) begin errs++; $display("FAIL ovf_norescue: got %h want 83", data_out); end
    tick(); idle();
    for (int i = 2; i < 8; i++) begin
      if (i == 5) begin
        writable = 0; #1;
        checks++; if (vram_we !== 1'b0) begin errs++; $display("FAIL ovf_pause: got %b want 0", vram_we); end
        tick(); tick(); writable = 1;
      end
      #1;
      checks++;
      if ({vram_we, vram_waddr, vram_wdata} !== {1'b1, 12'h100 + 12'(i), 8'h40 + 8'(i)}) begin
        errs++; $display("FAIL ovf_drain_%0d: got we=%b a=%h d=%h", i, vram_we, vram_waddr, vram_wdata);
      end
      tick();
    end
    checks++; if (vram_we !== 1'b0) begin errs++; $display("FAIL ovf_dropped: got %b want 0", vram_we); end
    writable = 0; tick();
  endtask

  task automatic test_irq();
    logic [7:0] v;
    do_reset();
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL irq_idle: got %b want 0", irq); end
    writable = 1; tick();
    checks++; if (irq !== 1'b1) begin errs++; $display("FAIL irq_vblank: got %b want 1", irq); end
    reg_rd(3, v);
    checks++; if (v !== 8'h01) begin errs++; $display("FAIL irq_frame1: got %h want 01", v); end
    reg_wr(0, 8'h02);
    checks++; if (irq !== 1'b1) begin errs++; $display("FAIL irq_clr_other: got %b want 1", irq); end
    reg_wr(0, 8'h01);
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL irq_clr: got %b want 0", irq); end
    writable = 0; tick();
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL irq_fall: got %b want 0", irq); end
    writable = 1; SELECT_irq_clr = 1; write_enable = 1; data_in = 8'h01;
    tick(); idle();
    checks++; if (irq !== 1'b1) begin errs++; $display("FAIL irq_set_wins: got %b want 1", irq); end
    reg_rd(3, v);
    checks++; if (v !== 8'h02) begin errs++; $display("FAIL irq_frame2: got %h want 02", v); end
    reg_wr(1, 8'h00);
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL irq_masked: got %b want 0", irq); end
    reg_wr(1, 8'hFF);
    reg_rd(1, v);
`ifdef GPU_CTRL_LINE_IRQ_EN
    checks++; if (v !== 8'h03) begin errs++; $display("FAIL irq_mask_rd: got %h want 03", v); end
`else
    checks++; if (v !== 8'h01) begin errs++; $display("FAIL irq_mask_rd: got %h want 01", v); end
`endif
    checks++; if (irq !== 1'b1) begin errs++; $display("FAIL irq_unmask: got %b want 1", irq); end
    reg_wr(2, 8'd100);
    reg_rd(2, v);
`ifdef GPU_CTRL_LINE_IRQ_EN
    checks++; if (v !== 8'd100) begin errs++; $display("FAIL line_cmp_rd: got %h want 64", v); end
`else
    checks++; if (v !== 8'h00) begin errs++; $display("FAIL line_cmp_rd: got %h want 00", v); end
`endif
    for (int i = 0; i < 253; i++) begin writable = 0; tick(); writable = 1; tick(); end
    reg_rd(3, v);
    checks++; if (v !== 8'hFF) begin errs++; $display("FAIL frame_255: got %h want ff", v); end
    writable = 0; tick(); writable = 1; tick();
    reg_rd(3, v);
    checks++; if (v !== 8'h00) begin errs++; $display("FAIL frame_wrap: got %h want 00", v); end
    writable = 0; tick();
  endtask

`ifdef GPU_CTRL_LINE_IRQ_EN
  task automatic test_line();
    logic [7:0] v;
    do_reset();
    reg_wr(2, 8'd100);
    reg_wr(1, 8'h02);
    vcounter = 10'd99; tick();
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL line_99: got %b want 0", irq); end
    vcounter = 10'd100; tick();
    checks++; if (irq !== 1'b1) begin errs++; $display("FAIL line_100: got %b want 1", irq); end
    reg_rd(0, v);
    checks++; if (v !== 8'h24) begin errs++; $display("FAIL line_status: got %h want 24", v); end
    reg_wr(0, 8'h02);
    tick(); tick(); tick();
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL line_hold: got %b want 0", irq); end
    vcounter = 10'd0; tick();
  endtask
`endif

  task automatic test_back_to_back();
    do_reset();
    push_wr(12'h020, 8'h11);
    writable = 1; address = 12'h021; data_in = 8'h22; SELECT_vram = 1; write_enable = 1; #1;
    checks++;
    if ({vram_we, vram_waddr, vram_wdata} !== {1'b1, 12'h020, 8'h11}) begin
      errs++; $display("FAIL b2b_0: got we=%b a=%h d=%h want 1 020 11", vram_we, vram_waddr, vram_wdata);
    end
    tick();
    address = 12'h022; data_in = 8'h33; #1;
    checks++;
    if ({vram_we, vram_waddr, vram_wdata} !== {1'b1, 12'h021, 8'h22}) begin
      errs++; $display("FAIL b2b_1: got we=%b a=%h d=%h want 1 021 22", vram_we, vram_waddr, vram_wdata);
    end
    tick(); idle(); #1;
    checks++;
    if ({vram_we, vram_waddr, vram_wdata} !== {1'b1, 12'h022, 8'h33}) begin
      errs++; $display("FAIL b2b_2: got we=%b a=%h d=%h want 1 022 33", vram_we, vram_waddr, vram_wdata);
    end
    tick();
    checks++; if (vram_we !== 1'b0) begin errs++; $display("FAIL b2b_empty: got %b want 0", vram_we); end
    address = 12'h030; data_in = 8'h44; SELECT_vram = 1; write_enable = 1; #1;
    checks++; if (vram_we !== 1'b0) begin errs++; $display("FAIL lat_same: got %b want 0", vram_we); end
    tick(); idle();
    checks++;
    if ({vram_we, vram_waddr, vram_wdata} !== {1'b1, 12'h030, 8'h44}) begin
      errs++; $display("FAIL lat_next: got we=%b a=%h d=%h want 1 030 44", vram_we, vram_waddr, vram_wdata);
    end
    tick();
    checks++; if (vram_we !== 1'b0) begin errs++; $display("FAIL lat_empty: got %b want 0", vram_we); end
    writable = 0; tick();
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int i = 0; i < 3; i++) push_wr(12'h040 + 12'(i), 8'h50 + 8'(i));
    writable = 1; #1;
    checks++; if (vram_we !== 1'b1) begin errs++; $display("FAIL mid_start: got %b want 1", vram_we); end
    tick();
    rst = 0; #1;
    checks++; if (vram_we !== 1'b0) begin errs++; $display("FAIL mid_async: got %b want 0", vram_we); end
    tick(); rst = 1; tick();
    checks++; if (vram_we !== 1'b0) begin errs++; $display("FAIL mid_after: got %b want 0", vram_we); end
    tick();
    checks++; if (vram_we !== 1'b0) begin errs++; $display("FAIL mid_after2: got %b want 0", vram_we); end
    writable = 0; tick();
  endtask

  initial begin
    test_reset();
    test_drain();
    test_overflow();
    test_irq();
`ifdef GPU_CTRL_LINE_IRQ_EN
    test_line();
`endif
    test_back_to_back();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/gpu_ctrl.md
# gpu_ctrl

CPU-bus front end for the next-generation GPU: replaces the single-bit VBLANK IRQ flop with a masked, multi-source interrupt controller and adds a write-posting FIFO. CPU VRAM writes can be issued at any time. They are queued and drained into the foreground/background VRAM ports only while the video timing reports `writable`. The block sits between the CPU bus decode and the `video_timing_m`/`foreground_m`/`background_m` instances inside the GPU top.

## Interface
Parameters:
- `ADDR_W`, 12, VRAM address width.
- `FIFO_DEPTH`, 8, write-posting entries; power of two, 2..64.
- `LINE_W`, 10, width of `vcounter` and of the line-compare register.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: GPU pixel clock, 12.5875 MHz.
- `rst` in 1: asynchronous, active-low reset.
- `data_in` in 8: CPU write data.
- `address` in ADDR_W: CPU VRAM address.
- `write_enable` in 1: CPU write strobe, one cycle per access.
- `SELECT_vram` in 1: access targets VRAM; the write is posted to the FIFO.
- `SELECT_status` in 1: read status.
- `SELECT_irq_clr` in 1: write-1-to-clear pending bits.
- `SELECT_irq_mask` in 1: read/write IRQ mask.
- `SELECT_line_cmp` in 1: read/write line-compare value, low 8 bits.
- `SELECT_frame` in 1: read frame counter.
- `data_out` out 8: read data; combinational mux of selected register, 0 when no read select is active.
- `writable` in 1: from video timing; VRAM may be written.
- `vcounter` in LINE_W: from video timing.
- `vram_wdata` out 8, `vram_waddr` out ADDR_W, `vram_we` out 1: drain port to foreground/background.
- `irq` out 1: `|(pending & mask)`.

## Operation
- **Push:** a cycle with `write_enable && SELECT_vram` pushes `{address, data_in}`.
  - If the FIFO is full (pre-pop count == FIFO_DEPTH), the push is dropped and sticky `overflow` sets.
  - A pop in the same cycle does not rescue the write.
- **Pop:**
  - `vram_we = writable && !empty`.
  - `vram_waddr`/`vram_wdata` present the FIFO head combinationally.
  - The entry pops on the same edge.
  - Pop rate is one per cycle.
- **Simultaneous push and pop** when not full: count unchanged, both take effect.
- **Status byte:** `{overflow, full, empty, 2'b0, line_pend, vblank_pend, writable}`. Reading status clears `overflow` on the read cycle edge.
- **vblank_pend** sets on a rising edge of `writable` (previous-cycle register 0, now 1). A falling edge does not set it.
- **line_pend** sets when `vcounter` changes (differs from its registered copy) and the new value equals `{2'b0, line_cmp}` zero-extended to LINE_W.
- **Clear:** a write with `SELECT_irq_clr` clears the pending bits whose `data_in` bit is 1 (bit0 vblank, bit1 line). If a set event coincides with its clear, set wins.
- **Mask:** bit0 vblank, bit1 line; other bits read 0.
- **Frame counter:** 8-bit, increments on each `writable` rising edge, wraps 255 -> 0.

## Timing
- Reset values:
  - FIFO empty, `overflow` 0, pending 0.
  - `mask` 8'h01, `line_cmp` 0, frame 0.
  - `writable`/`vcounter` history registers 0.
- Resulting output reset values: `vram_we` 0, `irq` 0, `data_out` 0.
- Push-to-drain latency: a write registered at edge t appears at the head after t. `vram_we` is first possible in the cycle following t, if `writable`.
- Pending bits register on the edge that detects the event. `irq` is combinational from registers, so it is high the cycle after the event.
- Reset mid-drain: FIFO contents are discarded and no further `vram_we` is issued.
- A FIFO_DEPTH-entry backlog drains in FIFO_DEPTH consecutive writable cycles. If `writable` drops, draining pauses and later resumes in order.

## Configuration
- `GPU_CTRL_LINE_IRQ_EN` defined: line-compare register, `line_pend`, `SELECT_line_cmp` read/write, and mask bit1 all present.
- Not defined:
  - `line_pend` is tied 0.
  - The line-compare register is absent and `SELECT_line_cmp` reads 0, with writes ignored.
  - Mask bit1 reads 0.
  - `irq` depends only on vblank.

## Structure
- Package `gpu_ctrl_pkg`: status bit index localparams, IRQ bit indices (`IRQ_VBLANK`=0, `IRQ_LINE`=1), and the mask reset value.
- Sub-module `gpu_write_fifo`: parametrised synchronous FIFO with width ADDR_W+8 and depth FIFO_DEPTH.
  - Ports: `push`, `pop`, `full`, `empty`, head data.
  - Pointers are log2(depth)+1 bits with a wrap bit.

## Test plan
- Reset -> `vram_we`=0, `irq`=0. Status read = 8'h20 when `writable`=0, 8'h21 when 1.
- `writable`=0; push 3 writes (0x010←0xAA, 0x011←0xBB, 0x012←0xCC). Raise `writable` -> `vram_we` high for exactly 3 cycles in order, then `empty`=1.
- With `writable`=0, push FIFO_DEPTH+1 writes -> last write dropped. Status = 8'hC0 (`overflow`, `full`). A second status read clears `overflow`.
- `writable` 0→1 -> `vblank_pend`=1, `irq`=1, frame counter +1. Write 8'h01 to `SELECT_irq_clr` -> `irq`=0. A clear coinciding with the next rising edge leaves pend=1.
- (`GPU_CTRL_LINE_IRQ_EN`) Set `line_cmp`=100 and mask=8'h02; sweep `vcounter` 99→100 -> `line_pend`=1, `irq`=1. `vcounter` held at 100 for further cycles -> no re-set after clear.
- Simultaneous push and pop with 1 entry queued -> count stays 1 and data order is preserved.
